reg_exec_ctrl: RTL and testbench
================================

Name: reg_exec_ctrl

Overview:
Initiator side of the 8-entry micro register bank. Accepts one instruction at a time over a valid/ready handshake and reads two operands through the bank's two read ports. Computes an 8-bit result and writes it back through the bank's single write port. Sits between the instruction decoder and the register bank; the bank's read path is combinational, and its write path is registered on the rising edge of clk.

Parameters:
DATA_W, 8, register/data width
ADDR_W, 3, register index width; sel_reg width is 2*ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
ins_valid  in  1  instruction present
ins_ready  out  1  controller can accept an instruction
ins_op  in  3  opcode
ins_rd  in  ADDR_W  destination and first-operand (X) index
ins_ry  in  ADDR_W  second-operand (Y) index
ins_imm  in  DATA_W  immediate for MOVI
sel_reg  out  2*ADDR_W  to bank: [2:0]=X/write index, [5:3]=Y index
w  out  1  to bank: write enable
dw  out  DATA_W  to bank: write data
rx  in  DATA_W  from bank: Fnd[sel_reg[2:0]]
ry  in  DATA_W  from bank: Fnd[sel_reg[5:3]]
result  out  DATA_W  last computed result
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
done  out  1  one-cycle pulse per completed instruction

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; sel_reg=0, w=0, dw=0, result=0, flag_z=0, flag_c=0, done=0. Any in-flight instruction is aborted with no bank write. w drops immediately and asynchronously.
- Opcodes:
  - 0 MOVI: rd<=imm
  - 1 MOV: rd<=ry
  - 2 ADD: rd<=rx+ry
  - 3 SUB: rd<=rx-ry
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 CMP: computes rx-ry and updates flags, no write.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: ins_ready=1. On ins_valid&&ins_ready at an edge, capture op/rd/ry/imm into internal registers and go to READ. ins_ready=0 in all other states.
- READ: sel_reg={ry_q,rd_q}, w=0. At the edge, latch rx and ry into operand registers.
- EXEC: compute the (DATA_W+1)-bit result from the latched operands. At the edge, register result[DATA_W-1:0] and update the flags:
  - flag_z = (result==0), for every op.
  - flag_c: ADD carry-out; SUB/CMP borrow (1 when rx<ry unsigned); 0 for MOVI, MOV, and the logic ops.
- WB: sel_reg={ry_q,rd_q}, dw=result, w=1 except for CMP (w=0). done=1 for exactly this cycle. Next state is IDLE.
- Latency: accept at edge N; READ occupies cycle N..N+1 and the bank write lands at edge N+3. The next instruction can be accepted at edge N+4. Throughput is 1 instruction per 4 cycles.
- rd==ry is legal: both operands read the same register, and the write happens after both are latched.
- A write in WB is visible to the READ of the next instruction, because the bank updates at the WB edge.
- sel_reg holds its last value in IDLE. w=0 and done=0 in every state except WB.
- ins_* is ignored when ins_ready=0. No instruction is dropped or duplicated.
- Wrap-around: ADD 0xFF+0x01 gives 0x00, Z=1, C=1. SUB 0x00-0x01 gives 0xFF, C=1.

Decomposition:
- Shared package (reg_exec_pkg): opcode constants (OP_MOVI … OP_CMP), FSM state encoding, DATA_W and ADDR_W defaults.
- One combinational sub-module, reg_exec_alu: inputs op, a, b, imm; outputs a (DATA_W+1)-bit result and a write-enable qualifier (0 for CMP).
- FSM, operand latches, flags and the handshake stay in reg_exec_ctrl.
- The bench connects reg_exec_ctrl to a bank model with identical semantics: reset-to-zero, async reset, write at Fnd[sel_reg[2:0]], combinational rx/ry.

Test Plan:
1. Reset then MOVI rd=3 imm=0x5A -> w=1 exactly 3 cycles after accept with sel_reg[2:0]=3 and dw=0x5A. Bank R3=0x5A, Z=0, C=0, one done pulse.
2. MOVI R1=0xFF, MOVI R2=0x01, ADD rd=1 ry=2 -> R1=0x00, Z=1, C=1. Then SUB rd=2 ry=1 (0x01-0x00) -> R2=0x01, C=0.
3. MOVI R4=0x10, CMP rd=4 ry=5 (R5=0) -> w never asserts and R4 stays 0x10. Then CMP rd=5 ry=4 -> Z=0, C=1, one done pulse each.
4. Hold ins_valid high with 3 back-to-back instructions -> ins_ready high only in IDLE, accepts exactly every 4 cycles, 3 done pulses, bank contents match the sequence.
5. MOVI R6=0xC3, then XOR rd=6 ry=6 -> R6=0x00, Z=1, C=0. AND/OR checks with 0xF0/0x0F -> 0x00 and 0xFF.
6. Assert rst=0 during EXEC of ADD -> w, done and flags go to 0 immediately, no write occurs, state IDLE. After release, ins_ready=1 and the next MOVI completes normally.

Source files
------------

// File: rtl/reg_exec_ctrl_pkg.sv
// Shared constants for the register-bank execution controller.
package reg_exec_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;

    localparam logic [2:0] OP_MOVI = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

endpackage

// File: rtl/reg_exec_ctrl_if.sv
// Instruction handshake and register-bank port bundles.
interface reg_exec_ins_if
    import reg_exec_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              ins_valid;
    logic              ins_ready;
    logic [2:0]        ins_op;
    logic [ADDR_W-1:0] ins_rd;
    logic [ADDR_W-1:0] ins_ry;
    logic [DATA_W-1:0] ins_imm;

    modport master (output ins_valid, ins_op, ins_rd, ins_ry, ins_imm, input ins_ready);
    modport slave  (input ins_valid, ins_op, ins_rd, ins_ry, ins_imm, output ins_ready);
endinterface

interface reg_exec_bank_if
    import reg_exec_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic [2*ADDR_W-1:0] sel_reg;
    logic                w;
    logic [DATA_W-1:0]   dw;
    logic [DATA_W-1:0]   rx;
    logic [DATA_W-1:0]   ry;

    modport master (output sel_reg, w, dw, input rx, ry);
    modport slave  (input sel_reg, w, dw, output rx, ry);
endinterface

// File: rtl/reg_exec_ctrl_alu.sv
// Combinational ALU: one extra result bit carries ADD carry-out / SUB borrow.
module reg_exec_alu
    import reg_exec_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W:0]   res,
    output logic              wr_en
);

    // Operation select; operands are zero-extended so the top bit is the carry/borrow
    always_comb begin
        res   = '0;
        wr_en = 1'b1;
        case (op)
            OP_MOVI: res = {1'b0, imm};
            OP_MOV:  res = {1'b0, b};
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            OP_XOR:  res = {1'b0, a ^ b};
            OP_CMP: begin
                res   = {1'b0, a} - {1'b0, b};
                wr_en = 1'b0;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/reg_exec_ctrl.sv
// Four-phase (IDLE/READ/EXEC/WB) instruction executor driving the register bank.
module reg_exec_ctrl
    import reg_exec_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    reg_exec_ins_if.slave     ins,
    reg_exec_bank_if.master   bank,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c,
    output logic              done
);

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d, ry_q, ry_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              fz_q, fz_d, fc_q, fc_d;
    logic [DATA_W:0]   alu_res;
    logic              alu_wr;

    reg_exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (op_q),
        .a     (opa_q),
        .b     (opb_q),
        .imm   (imm_q),
        .res   (alu_res),
        .wr_en (alu_wr)
    );

    // Handshake and bank outputs decode straight from state so reset clears w/done asynchronously
    assign ins.ins_ready = (state_q == ST_IDLE);
    assign bank.sel_reg  = {ry_q, rd_q};
    assign bank.dw       = res_q;
    assign bank.w        = (state_q == ST_WB) && alu_wr;
    assign done          = (state_q == ST_WB);
    assign result        = res_q;
    assign flag_z        = fz_q;
    assign flag_c        = fc_q;

    // Next-state, instruction capture, operand latch and result/flag update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        ry_d    = ry_q;
        imm_d   = imm_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        fz_d    = fz_q;
        fc_d    = fc_q;
        case (state_q)
            ST_IDLE: begin
                if (ins.ins_valid) begin
                    op_d    = ins.ins_op;
                    rd_d    = ins.ins_rd;
                    ry_d    = ins.ins_ry;
                    imm_d   = ins.ins_imm;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                opa_d   = bank.rx;
                opb_d   = bank.ry;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d   = alu_res[DATA_W-1:0];
                fz_d    = (alu_res[DATA_W-1:0] == '0);
                fc_d    = alu_res[DATA_W];
                state_d = ST_WB;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            ry_q    <= '0;
            imm_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            ry_q    <= ry_d;
            imm_q   <= imm_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
        end
    end

endmodule

// File: tb/tb_reg_exec_ctrl.sv
// Directed bench: reg_exec_ctrl against a behavioural 8-entry register bank.
module tb_reg_exec_ctrl;
    import reg_exec_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] result;
    logic       flag_z, flag_c, done;
    logic [7:0] fnd [8];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned done_tot = 0;

    reg_exec_ins_if  #(.DATA_W(8), .ADDR_W(3)) ins_if ();
    reg_exec_bank_if #(.DATA_W(8), .ADDR_W(3)) bank_if ();

    reg_exec_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .ins    (ins_if),
        .bank   (bank_if),
        .result (result),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Bank model: async clear, registered write, combinational reads
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) fnd[i] <= 8'h00;
        end else if (bank_if.w) begin
            fnd[bank_if.sel_reg[2:0]] <= bank_if.dw;
        end
    end
    assign bank_if.rx = fnd[bank_if.sel_reg[2:0]];
    assign bank_if.ry = fnd[bank_if.sel_reg[5:3]];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_tot <= done_tot + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !ins_if.ins_ready; i++) @(negedge clk);
        if (!ins_if.ins_ready) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Issue one instruction (called at a negedge) and check its WB cycle
    task automatic do_ins(input string tag, input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] ry, input logic [7:0] imm,
                          input logic exp_w, input logic [7:0] exp_dw);
        int unsigned lat, wn, dn;
        ins_if.ins_op    = op;
        ins_if.ins_rd    = rd;
        ins_if.ins_ry    = ry;
        ins_if.ins_imm   = imm;
        ins_if.ins_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk);
        #1 ins_if.ins_valid = 1'b0;
        lat = 99; wn = 0; dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bank_if.w) wn++;
            if (done) begin
                dn++;
                if (lat == 99) begin
                    lat = i;
                    check({tag, "_sel"}, bank_if.sel_reg[2:0], rd);
                    check({tag, "_dw"}, bank_if.dw, exp_dw);
                    check({tag, "_w"}, bank_if.w, exp_w);
                    check({tag, "_ready_wb"}, ins_if.ins_ready, 0);
                end
            end
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_done_cnt"}, dn, 1);
        check({tag, "_w_cnt"}, wn, exp_w ? 1 : 0);
    endtask

    logic [2:0]  b2b_op  [3];
    logic [2:0]  b2b_rd  [3];
    logic [2:0]  b2b_ry  [3];
    logic [7:0]  b2b_imm [3];
    int unsigned acc_t   [3];
    int unsigned d0;

    initial begin
        ins_if.ins_valid = 1'b0;
        ins_if.ins_op    = '0;
        ins_if.ins_rd    = '0;
        ins_if.ins_ry    = '0;
        ins_if.ins_imm   = '0;

        // Reset values
        #12;
        check("rst_sel", bank_if.sel_reg, 0);
        check("rst_w", bank_if.w, 0);
        check("rst_dw", bank_if.dw, 0);
        check("rst_result", result, 0);
        check("rst_fz", flag_z, 0);
        check("rst_fc", flag_c, 0);
        check("rst_done", done, 0);
        check("rst_ready", ins_if.ins_ready, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // 1: MOVI R3 = 0x5A
        do_ins("movi_r3", OP_MOVI, 3'd3, 3'd0, 8'h5A, 1'b1, 8'h5A);
        check("t1_r3", fnd[3], 8'h5A);
        check("t1_fz", flag_z, 0);
        check("t1_fc", flag_c, 0);

        // 2: add with wrap-around, then subtract
        do_ins("movi_r1", OP_MOVI, 3'd1, 3'd0, 8'hFF, 1'b1, 8'hFF);
        do_ins("movi_r2", OP_MOVI, 3'd2, 3'd0, 8'h01, 1'b1, 8'h01);
        do_ins("add_12", OP_ADD, 3'd1, 3'd2, 8'h00, 1'b1, 8'h00);
        check("t2_r1", fnd[1], 8'h00);
        check("t2_add_fz", flag_z, 1);
        check("t2_add_fc", flag_c, 1);
        do_ins("sub_21", OP_SUB, 3'd2, 3'd1, 8'h00, 1'b1, 8'h01);
        check("t2_r2", fnd[2], 8'h01);
        check("t2_sub_fz", flag_z, 0);
        check("t2_sub_fc", flag_c, 0);

        // 3: compare without write-back
        do_ins("movi_r4", OP_MOVI, 3'd4, 3'd0, 8'h10, 1'b1, 8'h10);
        do_ins("cmp_45", OP_CMP, 3'd4, 3'd5, 8'h00, 1'b0, 8'h10);
        check("t3_r4", fnd[4], 8'h10);
        check("t3_cmp45_fz", flag_z, 0);
        check("t3_cmp45_fc", flag_c, 0);
        do_ins("cmp_54", OP_CMP, 3'd5, 3'd4, 8'h00, 1'b0, 8'hF0);
        check("t3_r5", fnd[5], 8'h00);
        check("t3_cmp54_fz", flag_z, 0);
        check("t3_cmp54_fc", flag_c, 1);
        check("t3_result", result, 8'hF0);

        // 4: back-to-back with ins_valid held high
        b2b_op[0] = OP_MOVI; b2b_rd[0] = 3'd7; b2b_ry[0] = 3'd0; b2b_imm[0] = 8'h33;
        b2b_op[1] = OP_ADD;  b2b_rd[1] = 3'd7; b2b_ry[1] = 3'd3; b2b_imm[1] = 8'h00;
        b2b_op[2] = OP_SUB;  b2b_rd[2] = 3'd7; b2b_ry[2] = 3'd4; b2b_imm[2] = 8'h00;
        d0 = done_tot;
        for (int k = 0; k < 3; k++) begin
            ins_if.ins_op    = b2b_op[k];
            ins_if.ins_rd    = b2b_rd[k];
            ins_if.ins_ry    = b2b_ry[k];
            ins_if.ins_imm   = b2b_imm[k];
            ins_if.ins_valid = 1'b1;
            wait_ready("b2b");
            @(posedge clk);
            acc_t[k] = cyc;
            @(negedge clk);
        end
        ins_if.ins_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_gap01", acc_t[1] - acc_t[0], 4);
        check("t4_gap12", acc_t[2] - acc_t[1], 4);
        check("t4_dones", done_tot - d0, 3);
        check("t4_r7", fnd[7], 8'h7D);
        check("t4_result", result, 8'h7D);
        check("t4_fc", flag_c, 0);

        // 5: logic ops
        do_ins("movi_r6", OP_MOVI, 3'd6, 3'd0, 8'hC3, 1'b1, 8'hC3);
        do_ins("xor_66", OP_XOR, 3'd6, 3'd6, 8'h00, 1'b1, 8'h00);
        check("t5_r6", fnd[6], 8'h00);
        check("t5_xor_fz", flag_z, 1);
        check("t5_xor_fc", flag_c, 0);
        do_ins("movi_r0", OP_MOVI, 3'd0, 3'd0, 8'hF0, 1'b1, 8'hF0);
        do_ins("movi_r5", OP_MOVI, 3'd5, 3'd0, 8'h0F, 1'b1, 8'h0F);
        do_ins("and_05", OP_AND, 3'd0, 3'd5, 8'h00, 1'b1, 8'h00);
        check("t5_and_r0", fnd[0], 8'h00);
        check("t5_and_fz", flag_z, 1);
        do_ins("movi_r0b", OP_MOVI, 3'd0, 3'd0, 8'hF0, 1'b1, 8'hF0);
        do_ins("or_05", OP_OR, 3'd0, 3'd5, 8'h00, 1'b1, 8'hFF);
        check("t5_or_r0", fnd[0], 8'hFF);
        check("t5_or_fz", flag_z, 0);
        check("t5_or_fc", flag_c, 0);

        // 6: reset in the EXEC cycle of an ADD
        do_ins("cmp_50", OP_CMP, 3'd5, 3'd0, 8'h00, 1'b0, 8'h10);
        check("t6_pre_fc", flag_c, 1);
        ins_if.ins_op    = OP_ADD;
        ins_if.ins_rd    = 3'd1;
        ins_if.ins_ry    = 3'd2;
        ins_if.ins_imm   = 8'h00;
        ins_if.ins_valid = 1'b1;
        wait_ready("add_rst");
        @(posedge clk);
        #1 ins_if.ins_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        d0 = done_tot;
        rst = 1'b0;
        #1;
        check("t6_w", bank_if.w, 0);
        check("t6_done", done, 0);
        check("t6_fz", flag_z, 0);
        check("t6_fc", flag_c, 0);
        check("t6_result", result, 0);
        check("t6_ready", ins_if.ins_ready, 1);
        @(negedge clk) rst = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_done", done_tot - d0, 0);
        check("t6_r1", fnd[1], 8'h00);
        check("t6_ready_post", ins_if.ins_ready, 1);
        do_ins("movi_r2_post", OP_MOVI, 3'd2, 3'd0, 8'hA5, 1'b1, 8'hA5);
        check("t6_r2", fnd[2], 8'hA5);
        check("t6_post_result", result, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
